// File: rtl/bit_deserializer_pkg.sv
// bit_deserializer_pkg: shared word-size default for the serial-to-parallel path
package bit_deserializer_pkg;
   localparam int HACK_WORD_SER = 8;
endpackage

// File: rtl/bit_deserializer_or_reduce_n.sv
// or_reduce_n: balanced tree of 2-input ORs over an N-bit vector
module or_reduce_n #(
   parameter int N = 8
) (
   input  logic [N-1:0] bits,
   output logic         y
);
   if (N == 1) begin : g_leaf
      assign y = bits[0];
   end else begin : g_node
      logic lo, hi;
      or_reduce_n #(.N(N/2))     u_lo (.bits(bits[N/2-1:0]), .y(lo));
      or_reduce_n #(.N(N - N/2)) u_hi (.bits(bits[N-1:N/2]), .y(hi));
      assign y = lo | hi;
   end
endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer: packs an LSB-first valid/ready bit stream into WIDTH-bit words
import bit_deserializer_pkg::*;
module bit_deserializer #(
   parameter int WIDTH = HACK_WORD_SER,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             out_any
);
   logic [CW-1:0]    cnt;
   logic [WIDTH-2:0] shreg;
   logic             last, acc, done;
   assign last     = cnt == CW'(WIDTH - 1);
   assign in_ready = !flush && !(last && out_valid && !out_ready);
   assign acc      = in_valid && in_ready;
   assign done     = acc && last;
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt       <= '0;
         shreg     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         cnt       <= (flush || done) ? '0 : acc ? cnt + 1'b1 : cnt;
         shreg     <= (flush || done) ? '0 : acc ? shreg | ((WIDTH-1)'(in_bit) << cnt) : shreg;
         out_valid <= done || (out_valid && !out_ready);
         if (done) out_data <= {in_bit, shreg};
      end
   end
   or_reduce_n #(.N(WIDTH)) u_or (.bits(out_data), .y(out_any));
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: directed scoreboard bench for WIDTH=8 and WIDTH=2 builds
module tb_bit_deserializer;
   logic clk = 0;
   always #5 clk = ~clk;
   logic reset = 1, flush = 0, in_valid = 0, in_bit = 0, out_ready = 0;
   logic in_ready, out_valid, out_any;
   logic [7:0] out_data;
   logic in_valid2 = 0, in_bit2 = 0, out_ready2 = 0;
   logic in_ready2, out_valid2, out_any2;
   logic [1:0] out_data2;
   int checks = 0, errors = 0, stall_cnt = 0;
   logic [7:0] q[$];
   logic [1:0] q2[$];

   bit_deserializer #(.WIDTH(8)) dut (
      .clock(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .out_any(out_any));
   bit_deserializer #(.WIDTH(2)) dut2 (
      .clock(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid2), .in_bit(in_bit2),
      .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
      .out_any(out_any2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b);
      logic a;
      in_valid = 1; in_bit = b;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         a = in_ready;
         tick();
         if (a) break;
         stall_cnt++;
         if (n > 50) begin
            checks++; errors++;
            $display("FAIL send_timeout actual stalled required accept");
            break;
         end
      end
      in_valid = 0;
   endtask

   task automatic send_bits(input logic [7:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[i]);
   endtask

   task automatic send_word(input logic [7:0] w);
      q.push_back(w);
      send_bits(w, 8);
   endtask

   always @(negedge clk)
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word actual %h required none", out_data);
         end else begin
            logic [7:0] w;
            w = q.pop_front();
            chk("word", 32'(out_data), 32'(w));
            chk("any", 32'(out_any), 32'(|w));
         end
      end

   always @(negedge clk)
      if (!reset && out_valid2 && out_ready2) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word2 actual %b required none", out_data2);
         end else begin
            logic [1:0] w;
            w = q2.pop_front();
            chk("word2", 32'(out_data2), 32'(w));
            chk("any2", 32'(out_any2), 32'(|w));
         end
      end

   task automatic run_w2(input bit gaps);
      logic [7:0] seq;
      logic a;
      seq = 8'b1001_1001;
      q2.push_back(2'b01); q2.push_back(2'b10); q2.push_back(2'b01); q2.push_back(2'b10);
      for (int i = 0; i < 8; i++) begin
         for (int n = 0; ; n++) begin
            in_valid2  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready2 = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_bit2    = seq[i];
            @(negedge clk);
            a = in_valid2 && in_ready2;
            tick();
            if (a) break;
            if (n > 100) begin
               checks++; errors++;
               $display("FAIL w2_timeout actual stalled required accept");
               break;
            end
         end
      end
      in_valid2 = 0; out_ready2 = 1;
      repeat (3) tick();
      chk("w2_drained", q2.size(), 0);
   endtask

   initial begin
      logic [7:0] words [8];
      words = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h96};
      repeat (2) tick();
      reset = 0;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_any", 32'(out_any), 0);
      chk("rst_cnt", 32'(dut.cnt), 0);
      chk("rst_ready", 32'(in_ready), 1);
      tick();
      // single word, consumer always ready
      out_ready = 1;
      send_word(8'h8D);
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 1);
      tick();
      @(negedge clk);
      chk("t1_valid_drop", 32'(out_valid), 0);
      tick();
      // back-pressure: only the completing bit of the second word stalls
      out_ready = 0; stall_cnt = 0;
      send_word(8'hA5);
      q.push_back(8'h3C);
      send_bits(8'h3C, 7);
      chk("t2_no_early_stall", stall_cnt, 0);
      in_valid = 1; in_bit = 1'b0;
      @(negedge clk);
      chk("t2_stall", 32'(in_ready), 0);
      chk("t2_hold_data", 32'(out_data), 32'h A5);
      tick();
      @(negedge clk);
      chk("t2_still_stall", 32'(in_ready), 0);
      chk("t2_hold_valid", 32'(out_valid), 1);
      chk("t2_hold_data2", 32'(out_data), 32'hA5);
      tick();
      out_ready = 1;
      @(negedge clk);
      chk("t2_release", 32'(in_ready), 1);
      tick();
      in_valid = 0;
      @(negedge clk);
      chk("t2_next_valid", 32'(out_valid), 1);
      chk("t2_next_data", 32'(out_data), 32'h3C);
      tick(); tick();
      // continuous stream at full rate
      stall_cnt = 0;
      foreach (words[i]) send_word(words[i]);
      repeat (2) tick();
      chk("t3_no_stall", stall_cnt, 0);
      chk("t3_drained", q.size(), 0);
      // flush discards a partial word
      send_bits(8'h1F, 5);
      flush = 1;
      in_valid = 1; in_bit = 1;
      @(negedge clk);
      chk("t4_flush_ready", 32'(in_ready), 0);
      tick();
      flush = 0; in_valid = 0;
      chk("t4_cnt", 32'(dut.cnt), 0);
      send_word(8'h00);
      repeat (2) tick();
      chk("t4_drained", q.size(), 0);
      // reset while holding a word and filling the next
      out_ready = 0;
      q.push_back(8'h5A);
      send_bits(8'h5A, 8);
      send_bits(8'h07, 3);
      void'(q.pop_back());
      reset = 1;
      tick();
      reset = 0;
      @(negedge clk);
      chk("t5_valid", 32'(out_valid), 0);
      chk("t5_data", 32'(out_data), 0);
      chk("t5_any", 32'(out_any), 0);
      chk("t5_cnt", 32'(dut.cnt), 0);
      tick();
      out_ready = 1;
      send_word(8'hC3);
      repeat (2) tick();
      chk("t5_drained", q.size(), 0);
      // WIDTH=2 build, plain then with random gaps
      run_w2(0);
      run_w2(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end
endmodule
